line_clear_ctl: RTL and testbench
=================================

LINE_CLEAR_CTL -- requirements
Module: line_clear_ctl

Interface
REQ-001 SHALL have parameter ROWS, default 20, number of board rows; row 0 is the top row.
REQ-002 SHALL have parameter COLS, default 10, number of board columns and the row word width.
REQ-003 SHALL have port pclk  in  1  rising-edge clock for all logic.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  in  1  single-cycle request to scan the board after a piece lock.
REQ-006 SHALL have port level  in  4  current level, sampled on start acceptance.
REQ-007 SHALL have port vblnk  in  1  vertical blanking from the timing chain.
REQ-008 SHALL have port row_addr  out  5  board RAM row address.
REQ-009 SHALL have port row_rdata  in  COLS  board row read data, valid one cycle after row_addr.
REQ-010 SHALL have port row_wdata  out  COLS  board row write data.
REQ-011 SHALL have port row_we  out  1  board row write strobe.
REQ-012 SHALL have port busy  out  1  high from start acceptance until done.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port lines  out  5  number of full rows removed, held until the next start.
REQ-015 SHALL have port score_add  out  15  points increment, held until the next start.

Function
REQ-016 SHALL run states IDLE, GATE, READ, EVAL, WRITE, FILL, SCORE and DONE.
REQ-017 SHALL accept start only in IDLE, ignore start in any other state, and latch level on acceptance.
REQ-018 SHALL initialise both rd_ptr and wr_ptr to ROWS-1 and clear the internal line count on acceptance.
REQ-019 SHALL drive row_addr=rd_ptr in READ and move to EVAL on the next cycle.
REQ-020 SHALL in EVAL treat a row as full when row_rdata equals all-ones over COLS bits.
REQ-021 SHALL in EVAL, for a full row, increment the line count and not write.
REQ-022 SHALL in EVAL, for a non-full row with line count >0, go to WRITE.
REQ-023 SHALL in WRITE assert row_we=1 for exactly one cycle with row_addr=wr_ptr and row_wdata equal to the row captured in EVAL.
REQ-024 SHALL in EVAL, for a non-full row with line count 0, decrement wr_ptr and not write.
REQ-025 SHALL decrement rd_ptr after each row and, after row 0, go to FILL if line count >0, otherwise to SCORE.
REQ-026 SHALL in FILL write zero rows at wr_ptr down to row 0, one row per cycle, with row_we=1.
REQ-027 SHALL in SCORE set lines to the line count.
REQ-028 SHALL in SCORE set score_add = base x (level+1), with base 0/40/100/300/1200 for 0/1/2/3/>=4 lines.
REQ-029 SHALL compute score_add without overflow (maximum 19200 fits 15 bits).
REQ-030 SHALL assert done for one cycle in DONE, drop busy in the same cycle, and return to IDLE.
REQ-031 SHALL keep row_we=0 in all states except WRITE and FILL.
REQ-032 SHALL, with no full rows, assert done 2*ROWS+2 cycles after the accepting edge (42 at defaults) and perform no writes.
REQ-033 SHALL, when all ROWS rows are full, produce lines=ROWS, fill the whole board with zeros, and apply the >=4 base.

Reset
REQ-034 SHALL on rst force IDLE and set row_addr=0, row_wdata=0, row_we=0, busy=0, done=0, lines=0 and score_add=0.
REQ-035 SHALL on rst mid-operation abandon the scan immediately with no further writes; a partially compacted board is acceptable.

Configuration
REQ-036 SHALL with LINE_CLEAR_VBLNK_GATE_EN defined enter GATE after start acceptance and wait in GATE until vblnk=1 before READ, so all board writes begin inside blanking.
REQ-037 SHALL with LINE_CLEAR_VBLNK_GATE_EN undefined bypass GATE (IDLE goes directly to READ) and ignore vblnk.

Structure
REQ-038 SHALL place the state enumeration, the score base table constants and the default ROWS/COLS in shared package line_clear_pkg.
REQ-039 SHALL implement the score multiply in sub-module line_clear_score (combinational lines, level -> score_add).

Verification
REQ-040 SHALL cover: empty board, start, level=0 -> zero writes, done at cycle 42, lines=0, score_add=0.
REQ-041 SHALL cover: row 19 full, row 18=10'h001, level=2 -> row 19 written 10'h001, row 0 written 0, lines=1, score_add=120.
REQ-042 SHALL cover: rows 16-19 full, level=0 -> rows 0-3 zeroed, rows above shifted down by 4, lines=4, score_add=1200.
REQ-043 SHALL cover: start pulsed while busy -> ignored, single done pulse.
REQ-044 SHALL cover: rst asserted in WRITE -> next cycle row_we=0, busy=0 and state IDLE.
REQ-045 SHALL cover: LINE_CLEAR_VBLNK_GATE_EN defined, vblnk=0 for 100 cycles -> busy=1 with no row_addr activity, then scan starts the cycle after vblnk=1.

Source files
------------

// File: rtl/line_clear_pkg.sv
// line_clear_pkg: shared state encoding, score base table and default board size for line_clear_ctl.
package line_clear_pkg;
  localparam int ROWS_DEF = 20;
  localparam int COLS_DEF = 10;
  localparam logic [10:0] BASE_0 = 11'd0;
  localparam logic [10:0] BASE_1 = 11'd40;
  localparam logic [10:0] BASE_2 = 11'd100;
  localparam logic [10:0] BASE_3 = 11'd300;
  localparam logic [10:0] BASE_4 = 11'd1200;
  typedef enum logic [2:0] {
    S_IDLE, S_GATE, S_READ, S_EVAL, S_WRITE, S_FILL, S_SCORE, S_DONE
  } state_t;
endpackage

// File: rtl/line_clear_score.sv
// line_clear_score: combinational points for a clear, base(lines) x (level+1).
module line_clear_score
  import line_clear_pkg::*;
(
  input  logic [4:0]  lines_i,
  input  logic [3:0]  level_i,
  output logic [14:0] score_o
);
  logic [10:0] base;
  always_comb begin
    base = lines_i == 5'd0 ? BASE_0 :
           lines_i == 5'd1 ? BASE_1 :
           lines_i == 5'd2 ? BASE_2 :
           lines_i == 5'd3 ? BASE_3 : BASE_4;
    score_o = 15'(base) * 15'({1'b0, level_i} + 5'd1);
  end
endmodule

// File: rtl/line_clear_ctl.sv
// line_clear_ctl: scans the board bottom-up, compacts out full rows, zero-fills the top and scores.
// Optional LINE_CLEAR_VBLNK_GATE_EN holds the scan in GATE until vertical blanking.
module line_clear_ctl
  import line_clear_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic            pclk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      level,
  input  logic            vblnk,
  output logic [4:0]      row_addr,
  input  logic [COLS-1:0] row_rdata,
  output logic [COLS-1:0] row_wdata,
  output logic            row_we,
  output logic            busy,
  output logic            done,
  output logic [4:0]      lines,
  output logic [14:0]     score_add
);
`ifdef LINE_CLEAR_VBLNK_GATE_EN
  localparam state_t S_FIRST = S_GATE;
`else
  localparam state_t S_FIRST = S_READ;
  logic unused_vblnk;
  assign unused_vblnk = vblnk;
`endif
  state_t state_q, state_d, row_next;
  logic [4:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, cnt_q, cnt_d, lines_q, lines_d;
  logic [3:0] level_q, level_d;
  logic [COLS-1:0] row_q, row_d;
  logic [14:0] score_q, score_d, score_w;
  logic accept, full, to_write, row_end, wr_dec;

  line_clear_score u_score (.lines_i(cnt_q), .level_i(level_q), .score_o(score_w));

  always_ff @(posedge pclk) begin
    state_q <= rst ? S_IDLE : state_d;
  end

  always_comb begin
    accept   = state_q == S_IDLE && start;
    full     = row_rdata == {COLS{1'b1}};
    to_write = state_q == S_EVAL && !full && cnt_q != 5'd0;
    row_end  = (state_q == S_EVAL && !to_write) || state_q == S_WRITE;
    cnt_d    = accept ? 5'd0 : (state_q == S_EVAL && full) ? cnt_q + 5'd1 : cnt_q;
    row_next = rd_ptr_q != 5'd0 ? S_READ : cnt_d != 5'd0 ? S_FILL : S_SCORE;
    state_d  = state_q;
    case (state_q)
      S_IDLE:  state_d = start ? S_FIRST : S_IDLE;
`ifdef LINE_CLEAR_VBLNK_GATE_EN
      S_GATE:  state_d = vblnk ? S_READ : S_GATE;
`else
      S_GATE:  state_d = S_READ;
`endif
      S_READ:  state_d = S_EVAL;
      S_EVAL:  state_d = to_write ? S_WRITE : row_next;
      S_WRITE: state_d = row_next;
      S_FILL:  state_d = wr_ptr_q == 5'd0 ? S_SCORE : S_FILL;
      S_SCORE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // wr_ptr only moves past rows that are final: kept-in-place, rewritten or zero-filled
  always_comb begin
    wr_dec   = state_q == S_WRITE || state_q == S_FILL ||
               (state_q == S_EVAL && !full && cnt_q == 5'd0);
    rd_ptr_d = accept ? 5'(ROWS - 1) : row_end ? rd_ptr_q - 5'd1 : rd_ptr_q;
    wr_ptr_d = accept ? 5'(ROWS - 1) : wr_dec ? wr_ptr_q - 5'd1 : wr_ptr_q;
    row_d    = to_write ? row_rdata : row_q;
    level_d  = accept ? level : level_q;
    lines_d  = accept ? 5'd0 : state_q == S_SCORE ? cnt_q : lines_q;
    score_d  = accept ? 15'd0 : state_q == S_SCORE ? score_w : score_q;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      row_q    <= '0;
      level_q  <= '0;
      lines_q  <= '0;
      score_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      level_q  <= level_d;
      lines_q  <= lines_d;
      score_q  <= score_d;
    end
  end

  always_comb begin
    row_addr  = state_q == S_READ ? rd_ptr_q :
                (state_q == S_WRITE || state_q == S_FILL) ? wr_ptr_q : 5'd0;
    row_wdata = state_q == S_WRITE ? row_q : '0;
    row_we    = state_q == S_WRITE || state_q == S_FILL;
    busy      = state_q != S_IDLE && state_q != S_DONE;
    done      = state_q == S_DONE;
    lines     = lines_q;
    score_add = score_q;
  end
endmodule

// File: tb/tb_line_clear_ctl.sv
// tb_line_clear_ctl: table-driven board scenarios plus start-while-busy, reset-in-WRITE and vblank gating.
module tb_line_clear_ctl;
  import line_clear_pkg::*;
  localparam int ROWS = 20;
  localparam int COLS = 10;
`ifdef LINE_CLEAR_VBLNK_GATE_EN
  localparam int GATE_LAT = 1;
`else
  localparam int GATE_LAT = 0;
`endif
  logic pclk = 1'b0, rst = 1'b1, start = 1'b0, vblnk = 1'b1, load = 1'b0;
  logic [3:0] level = 4'd0;
  logic [4:0] row_addr, lines;
  logic [COLS-1:0] row_rdata, row_wdata;
  logic row_we, busy, done;
  logic [14:0] score_add;
  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] img [ROWS];
  logic [COLS-1:0] exp_b [ROWS];
  int total = 0, bad = 0;

  line_clear_ctl dut (
    .pclk(pclk), .rst(rst), .start(start), .level(level), .vblnk(vblnk),
    .row_addr(row_addr), .row_rdata(row_rdata), .row_wdata(row_wdata), .row_we(row_we),
    .busy(busy), .done(done), .lines(lines), .score_add(score_add)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (load) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= img[r];
    end else if (row_we) mem[row_addr] <= row_wdata;
    row_rdata <= mem[row_addr];
  end

  typedef struct {
    logic [19:0] mask;
    logic [3:0]  lvl;
    int exp_lines;
    int exp_score;
    int exp_we;
    int exp_cyc;
  } vec_t;
  vec_t v [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Full rows hold all-ones; other rows get a distinct non-full pattern (row 18 = 1).
  task automatic prep(input logic [19:0] mask);
    int k;
    for (int r = 0; r < ROWS; r++) img[r] = mask[r] ? {COLS{1'b1}} : COLS'(ROWS - 1 - r);
    k = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--)
      if (!mask[r]) begin exp_b[k] = img[r]; k--; end
    for (int r = k; r >= 0; r--) exp_b[r] = '0;
    @(negedge pclk) load = 1'b1;
    @(negedge pclk) load = 1'b0;
  endtask

  task automatic run(input logic [3:0] lvl, output int cyc, output int we, output int dones);
    level = lvl;
    start = 1'b1;
    @(negedge pclk) start = 1'b0;
    cyc = 0; we = 0; dones = 0;
    for (int n = 1; n < 300; n++) begin
      if (row_we) we++;
      if (done) begin cyc = n; dones++; break; end
      @(negedge pclk);
    end
  endtask

  initial begin
    int cyc, we, nd, nbad, first, found;
    v[0] = '{20'h00000, 4'd0,  0,     0,  0, 42};
    v[1] = '{20'h80000, 4'd2,  1,   120, 20, 62};
    v[2] = '{20'hF0000, 4'd0,  4,  1200, 20, 62};
    v[3] = '{20'hFFFFF, 4'd15, 20, 19200, 20, 62};
    v[4] = '{20'h00001, 4'd1,  1,    80,  1, 43};
    v[5] = '{20'h00408, 4'd3,  2,   400, 11, 53};
    v[6] = '{20'h000E0, 4'd9,  3,  3000,  8, 50};
    repeat (3) @(negedge pclk);
    chk("rst busy", busy, 0);
    chk("rst outs", {done, row_we, row_addr, row_wdata, lines, score_add}, 0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      prep(v[i].mask);
      run(v[i].lvl, cyc, we, nd);
      chk($sformatf("v%0d cycles", i), cyc, v[i].exp_cyc + GATE_LAT);
      chk($sformatf("v%0d writes", i), we, v[i].exp_we);
      chk($sformatf("v%0d busy_at_done", i), busy, 0);
      @(negedge pclk);
      chk($sformatf("v%0d lines", i), lines, v[i].exp_lines);
      chk($sformatf("v%0d score", i), score_add, v[i].exp_score);
      nbad = 0;
      for (int r = 0; r < ROWS; r++) if (mem[r] !== exp_b[r]) nbad++;
      chk($sformatf("v%0d board_bad_rows", i), nbad, 0);
    end
    // second start while busy must be ignored
    prep(20'h00000);
    start = 1'b1;
    @(negedge pclk) start = 1'b0;
    nd = 0; first = 0;
    for (int n = 1; n <= 90; n++) begin
      start = n == 5;
      if (done) begin nd++; if (first == 0) first = n; end
      @(negedge pclk);
    end
    start = 1'b0;
    chk("busy_start done_count", nd, 1);
    chk("busy_start done_cycle", first, 42 + GATE_LAT);
    // reset while writing
    prep(20'h80000);
    level = 4'd2;
    start = 1'b1;
    @(negedge pclk) start = 1'b0;
    found = 0;
    for (int n = 1; n < 50 && found == 0; n++) begin
      if (row_we) found = 1; else @(negedge pclk);
    end
    chk("rst_write reached", found, 1);
    rst = 1'b1;
    @(negedge pclk);
    chk("rst_write we", row_we, 0);
    chk("rst_write busy", busy, 0);
    chk("rst_write state", dut.state_q, S_IDLE);
    rst = 1'b0;
    repeat (3) @(negedge pclk);
    chk("rst_write idle", {busy, row_we, done}, 0);
`ifdef LINE_CLEAR_VBLNK_GATE_EN
    prep(20'h00000);
    vblnk = 1'b0;
    start = 1'b1;
    @(negedge pclk) start = 1'b0;
    nbad = 0;
    for (int n = 0; n < 100; n++) begin
      if (!busy || row_addr != 5'd0 || row_we) nbad++;
      @(negedge pclk);
    end
    chk("gate hold", nbad, 0);
    vblnk = 1'b1;
    @(negedge pclk);
    chk("gate release addr", row_addr, ROWS - 1);
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      if (done) found = 1; else @(negedge pclk);
    end
    chk("gate done", found, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
